// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared state encoding and player ids for match_scoreboard
package score_pkg;

    typedef enum logic [1:0] {
        ST_PLAY_P1    = 2'd0,
        ST_PLAY_P2    = 2'd1,
        ST_WAIT_KICK  = 2'd2,
        ST_MATCH_OVER = 2'd3
    } st_e;

    localparam logic P1 = 1'b0;
    localparam logic P2 = 1'b1;

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - two-flop input sampler with rising-edge detect
module edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic f0_q;
    logic f1_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f0_q <= 1'b0;
            f1_q <= 1'b0;
        end else begin
            f0_q <= d;
            f1_q <= f0_q;
        end
    end

    // One event per high level, visible in the cycle after the first sample.
    assign rise = f0_q & ~f1_q;

endmodule

// File: rtl/match_scoreboard.sv
// rtl/match_scoreboard.sv - two-player point/set scorekeeper with serve tracking
// Optional feature macro: WIN_BY_TWO_EN (set requires a two-point lead, deuce reload).
module match_scoreboard
    import score_pkg::*;
#(
    parameter int PTS_W       = 3,
    parameter int PTS_TO_WIN  = 5,
    parameter int SETS_W      = 3,
    parameter int SETS_TO_WIN = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              win1,
    input  logic              win2,
    input  logic              kick,
    output logic [PTS_W-1:0]  sc1,
    output logic [PTS_W-1:0]  sc2,
    output logic [SETS_W-1:0] tsc1,
    output logic [SETS_W-1:0] tsc2,
    output logic [1:0]        st,
    output logic              toIDLE
);

    localparam logic [PTS_W:0]  PTS_ONE  = (PTS_W+1)'(1);
    localparam logic [PTS_W:0]  PTS_T    = (PTS_W+1)'(PTS_TO_WIN);
    localparam logic [SETS_W:0] SETS_ONE = (SETS_W+1)'(1);
    localparam logic [SETS_W:0] SETS_T   = (SETS_W+1)'(SETS_TO_WIN);
`ifdef WIN_BY_TWO_EN
    localparam logic [PTS_W:0]  PTS_TWO  = (PTS_W+1)'(2);
    localparam logic [PTS_W:0]  PTS_M1   = (PTS_W+1)'(PTS_TO_WIN - 1);
`endif

    logic w1_rise;
    logic w2_rise;
    logic kick_rise;

    edge_sync u_sync_win1 (.clk(clk), .reset(reset), .d(win1), .rise(w1_rise));
    edge_sync u_sync_win2 (.clk(clk), .reset(reset), .d(win2), .rise(w2_rise));
    edge_sync u_sync_kick (.clk(clk), .reset(reset), .d(kick), .rise(kick_rise));

    st_e               st_q, st_d;
    logic              server_q, server_d;
    logic [PTS_W-1:0]  sc1_q, sc1_d;
    logic [PTS_W-1:0]  sc2_q, sc2_d;
    logic [SETS_W-1:0] tsc1_q, tsc1_d;
    logic [SETS_W-1:0] tsc2_q, tsc2_d;
    logic              toidle_q, toidle_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q     <= ST_WAIT_KICK;
            server_q <= P1;
            sc1_q    <= '0;
            sc2_q    <= '0;
            tsc1_q   <= '0;
            tsc2_q   <= '0;
            toidle_q <= 1'b0;
        end else begin
            st_q     <= st_d;
            server_q <= server_d;
            sc1_q    <= sc1_d;
            sc2_q    <= sc2_d;
            tsc1_q   <= tsc1_d;
            tsc2_q   <= tsc2_d;
            toidle_q <= toidle_d;
        end
    end

    // Point arithmetic is one bit wider than the counters so the compare never wraps.
    logic              scorer;
    logic [PTS_W:0]    pts_new;
    logic [SETS_W:0]   sets_new;
    logic              set_won;
    logic              deuce;
    logic              match_won;
`ifdef WIN_BY_TWO_EN
    logic [PTS_W:0]    pts_other;
`endif

    always_comb begin
        scorer   = w2_rise ? P2 : P1;
        pts_new  = ((scorer == P1) ? {1'b0, sc1_q} : {1'b0, sc2_q}) + PTS_ONE;
        sets_new = ((scorer == P1) ? {1'b0, tsc1_q} : {1'b0, tsc2_q}) + SETS_ONE;
`ifdef WIN_BY_TWO_EN
        pts_other = (scorer == P1) ? {1'b0, sc2_q} : {1'b0, sc1_q};
        set_won   = (pts_new >= PTS_T) && (pts_new >= pts_other + PTS_TWO);
        // Tie at or past game point folds back to PTS_TO_WIN-1 so widths stay bounded.
        deuce     = !set_won && (pts_new == pts_other) && (pts_new >= PTS_M1);
`else
        set_won   = (pts_new >= PTS_T);
        deuce     = 1'b0;
`endif
        match_won = (sets_new >= SETS_T);
    end

    always_comb begin
        st_d     = st_q;
        server_d = server_q;
        sc1_d    = sc1_q;
        sc2_d    = sc2_q;
        tsc1_d   = tsc1_q;
        tsc2_d   = tsc2_q;
        toidle_d = 1'b0;

        unique case (st_q)
            ST_WAIT_KICK: begin
                if (kick_rise) begin
                    st_d = (server_q == P1) ? ST_PLAY_P1 : ST_PLAY_P2;
                end
            end
            ST_PLAY_P1, ST_PLAY_P2: begin
                if (w1_rise ^ w2_rise) begin
                    server_d = (scorer == P1) ? P2 : P1;
                    st_d     = ST_WAIT_KICK;
                    if (set_won) begin
                        sc1_d = '0;
                        sc2_d = '0;
                        if (scorer == P1) begin
                            tsc1_d = sets_new[SETS_W-1:0];
                        end else begin
                            tsc2_d = sets_new[SETS_W-1:0];
                        end
                        if (match_won) begin
                            st_d     = ST_MATCH_OVER;
                            toidle_d = 1'b1;
                        end
                    end else if (deuce) begin
`ifdef WIN_BY_TWO_EN
                        sc1_d = PTS_M1[PTS_W-1:0];
                        sc2_d = PTS_M1[PTS_W-1:0];
`endif
                    end else if (scorer == P1) begin
                        sc1_d = pts_new[PTS_W-1:0];
                    end else begin
                        sc2_d = pts_new[PTS_W-1:0];
                    end
                end
            end
            ST_MATCH_OVER: begin
                if (kick_rise) begin
                    sc1_d    = '0;
                    sc2_d    = '0;
                    tsc1_d   = '0;
                    tsc2_d   = '0;
                    server_d = P1;
                    st_d     = ST_WAIT_KICK;
                end
            end
            default: st_d = ST_WAIT_KICK;
        endcase
    end

    assign sc1    = sc1_q;
    assign sc2    = sc2_q;
    assign tsc1   = tsc1_q;
    assign tsc2   = tsc2_q;
    assign st     = st_q;
    assign toIDLE = toidle_q;

endmodule

// File: tb/tb_match_scoreboard.sv
// tb/tb_match_scoreboard.sv - self-checking bench for match_scoreboard
module tb_match_scoreboard;

    localparam int PTS  = 5;
    localparam int SETS = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       win1, win2, kick;
    logic [2:0] sc1, sc2, tsc1, tsc2;
    logic [1:0] st;
    logic       toIDLE;

    match_scoreboard #(.PTS_W(3), .PTS_TO_WIN(PTS), .SETS_W(3), .SETS_TO_WIN(SETS)) dut (
        .clk(clk), .reset(reset), .win1(win1), .win2(win2), .kick(kick),
        .sc1(sc1), .sc2(sc2), .tsc1(tsc1), .tsc2(tsc2), .st(st), .toIDLE(toIDLE)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int m_sc1, m_sc2, m_tsc1, m_tsc2, m_st, m_server, m_toidle;

    wire [14:0] dut_vec = {sc1, sc2, tsc1, tsc2, st, toIDLE};

    function automatic logic [14:0] exp_vec();
        return {3'(m_sc1), 3'(m_sc2), 3'(m_tsc1), 3'(m_tsc2), 2'(m_st), 1'(m_toidle)};
    endfunction

    task automatic model_reset();
        m_sc1 = 0; m_sc2 = 0; m_tsc1 = 0; m_tsc2 = 0;
        m_st = 2; m_server = 1; m_toidle = 0;
    endtask

    task automatic model_point(input int p);
        int mine, other, sets;
        bit won;
        mine  = (p == 1) ? m_sc1 + 1 : m_sc2 + 1;
        other = (p == 1) ? m_sc2 : m_sc1;
`ifdef WIN_BY_TWO_EN
        won = (mine >= PTS) && (mine - other >= 2);
`else
        won = (mine >= PTS);
`endif
        m_server = (p == 1) ? 2 : 1;
        m_st = 2;
        if (won) begin
            m_sc1 = 0; m_sc2 = 0;
            sets = (p == 1) ? m_tsc1 + 1 : m_tsc2 + 1;
            if (p == 1) m_tsc1 = sets; else m_tsc2 = sets;
            if (sets == SETS) begin
                m_st = 3;
                m_toidle = 1;
            end
        end else begin
`ifdef WIN_BY_TWO_EN
            if (mine == other && mine >= PTS - 1) begin
                mine = PTS - 1;
                other = PTS - 1;
            end
`endif
            if (p == 1) begin m_sc1 = mine; m_sc2 = other; end
            else        begin m_sc2 = mine; m_sc1 = other; end
        end
    endtask

    task automatic model_step(input logic w1, input logic w2, input logic k);
        m_toidle = 0;
        case (m_st)
            2: if (k) m_st = (m_server == 1) ? 0 : 1;
            0, 1: if (w1 != w2) model_point(w1 ? 1 : 2);
            3: if (k) begin model_reset(); end
            default: ;
        endcase
    endtask

    task automatic pulse(input logic w1, input logic w2, input logic k);
        @(negedge clk);
        win1 = w1; win2 = w2; kick = k;
        @(negedge clk);
        win1 = 1'b0; win2 = 1'b0; kick = 1'b0;
        @(negedge clk);
        model_step(w1, w2, k);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        win1 = 1'b0; win2 = 1'b0; kick = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        win1 = 1'b0; win2 = 1'b0; kick = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        checks++;
        if (dut_vec !== 15'b000_000_000_000_10_0) begin
            failures++;
            $display("FAIL reset_values: got %b expected %b", dut_vec, 15'b000_000_000_000_10_0);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL reset_release: got %b expected %b", dut_vec, exp_vec());
        end
    endtask

    task automatic test_kick_and_hold();
        @(negedge clk);
        kick = 1'b1;
        @(negedge clk);
        kick = 1'b0;
        checks++;
        if (st !== 2'd2) begin
            failures++;
            $display("FAIL kick_one_edge: got st=%0d expected 2", st);
        end
        @(negedge clk);
        model_step(0, 0, 1);
        checks++;
        if (st !== 2'd0 || dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL kick_two_edges: got %b expected %b", dut_vec, exp_vec());
        end
        win1 = 1'b1;
        repeat (10) @(negedge clk);
        win1 = 1'b0;
        @(negedge clk);
        model_step(1, 0, 0);
        checks++;
        if (sc1 !== 3'd1 || st !== 2'd2 || dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL win1_held: got %b expected %b", dut_vec, exp_vec());
        end
    endtask

    task automatic test_wait_ignore();
        pulse(0, 1, 0);
        checks++;
        if (sc2 !== 3'd0 || st !== 2'd2 || dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL win_in_wait: got %b expected %b", dut_vec, exp_vec());
        end
        pulse(0, 0, 1);
        checks++;
        if (st !== 2'd1 || dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL loser_serves: got st=%0d expected 1", st);
        end
    endtask

    task automatic test_simultaneous();
        pulse(1, 1, 0);
        checks++;
        if (st !== 2'd1 || sc1 !== 3'd1 || sc2 !== 3'd0 || dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL both_wins: got %b expected %b", dut_vec, exp_vec());
        end
        pulse(1, 0, 1);
        checks++;
        if (dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL win_with_kick: got %b expected %b", dut_vec, exp_vec());
        end
    endtask

    task automatic test_match();
        do_reset();
        for (int s = 0; s < SETS; s++) begin
            for (int p = 0; p < PTS; p++) begin
                pulse(0, 0, 1);
                pulse(1, 0, 0);
                checks++;
                if (dut_vec !== exp_vec()) begin
                    failures++;
                    $display("FAIL match_point s%0d p%0d: got %b expected %b", s, p, dut_vec, exp_vec());
                end
            end
            checks++;
            if (tsc1 !== 3'(s + 1) || sc1 !== 3'd0 || sc2 !== 3'd0) begin
                failures++;
                $display("FAIL set_end s%0d: got tsc1=%0d sc1=%0d expected tsc1=%0d sc1=0", s, tsc1, sc1, s + 1);
            end
        end
        checks++;
        if (st !== 2'd3 || toIDLE !== 1'b1) begin
            failures++;
            $display("FAIL match_over: got st=%0d toIDLE=%b expected 3 1", st, toIDLE);
        end
        @(negedge clk);
        m_toidle = 0;
        checks++;
        if (toIDLE !== 1'b0 || st !== 2'd3 || tsc1 !== 3'd3) begin
            failures++;
            $display("FAIL toidle_pulse: got toIDLE=%b st=%0d expected 0 3", toIDLE, st);
        end
        pulse(0, 1, 0);
        checks++;
        if (dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL win_in_over: got %b expected %b", dut_vec, exp_vec());
        end
        pulse(0, 0, 1);
        checks++;
        if (dut_vec !== 15'b000_000_000_000_10_0) begin
            failures++;
            $display("FAIL over_kick: got %b expected %b", dut_vec, 15'b000_000_000_000_10_0);
        end
        pulse(0, 0, 1);
        checks++;
        if (st !== 2'd0 || dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL restart_serve: got st=%0d expected 0", st);
        end
    endtask

    task automatic test_reset_mid_rally();
        pulse(1, 0, 0);
        pulse(0, 0, 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if (dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL async_reset: got %b expected %b", dut_vec, exp_vec());
        end
        win1 = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL held_through_reset: got %b expected %b", dut_vec, exp_vec());
        end
        win1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_boundary();
        do_reset();
        for (int i = 0; i < PTS - 1; i++) begin
            pulse(0, 0, 1);
            pulse(1, 0, 0);
            pulse(0, 0, 1);
            pulse(0, 1, 0);
        end
        checks++;
        if (sc1 !== 3'(PTS - 1) || sc2 !== 3'(PTS - 1) || dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL four_all: got sc1=%0d sc2=%0d expected %0d", sc1, sc2, PTS - 1);
        end
        pulse(0, 0, 1);
        pulse(1, 0, 0);
`ifdef WIN_BY_TWO_EN
        checks++;
        if (sc1 !== 3'd5 || sc2 !== 3'd4 || tsc1 !== 3'd0 || dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL adv_p1: got %b expected %b", dut_vec, exp_vec());
        end
        pulse(0, 0, 1);
        pulse(0, 1, 0);
        checks++;
        if (sc1 !== 3'd4 || sc2 !== 3'd4 || dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL deuce_reload: got %b expected %b", dut_vec, exp_vec());
        end
        pulse(0, 0, 1);
        pulse(1, 0, 0);
        pulse(0, 0, 1);
        pulse(1, 0, 0);
`endif
        checks++;
        if (tsc1 !== 3'd1 || sc1 !== 3'd0 || sc2 !== 3'd0 || dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL set_at_boundary: got %b expected %b", dut_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        logic w1, w2, k;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i % 150 == 149) do_reset();
            k  = ($urandom_range(0, 99) < 45);
            w1 = ($urandom_range(0, 99) < 40);
            w2 = ($urandom_range(0, 99) < 35);
            pulse(w1, w2, k);
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL random_%0d w1=%b w2=%b k=%b: got %b expected %b", i, w1, w2, k, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_kick_and_hold();
        test_wait_ignore();
        test_simultaneous();
        test_match();
        test_reset_mid_rally();
        test_boundary();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
